// File: rtl/aes_pkg.sv
// Shared widths and issue-state encoding for the AES plaintext block packer.
package aes_pkg;
    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOCK = 2'd2
    } issue_state_t;
endpackage

// File: rtl/aes_pack_issue_fsm.sv
// Issue control for the block packer: hold-register ownership, encoder handshake,
// post-issue ready blackout and the issued-block counter.
//
// state | meaning
// IDLE  | hold register empty
// PEND  | hold register full, waiting for encoder ready
// LOCK  | post-issue blackout, encoder ready ignored for READY_LAT cycles
module aes_pack_issue_fsm
    import aes_pkg::*;
#(
    parameter int READY_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_complete,
    input  logic             i_encoder_ready,
    output logic             o_take,
    output logic             o_valid,
    output logic             o_hold_full,
    output logic             o_idle,
    output logic [CNT_W-1:0] o_count
);
    localparam logic [2:0] LAT_LOAD = 3'(READY_LAT);
    localparam logic [2:0] LAT_LAST = 3'd1;

    issue_state_t     r_state;
    logic [2:0]       r_lat;
    logic             r_valid;
    logic             r_hold_full;
    logic [CNT_W-1:0] r_count;
    logic             w_take;

    assign w_take      = (r_state == PEND) && i_encoder_ready;
    assign o_take      = w_take;
    assign o_valid     = r_valid;
    assign o_hold_full = r_hold_full;
    assign o_idle      = (r_state == IDLE);
    assign o_count     = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_lat       <= '0;
            r_valid     <= 1'b0;
            r_hold_full <= 1'b0;
            r_count     <= '0;
        end else begin
            r_valid <= 1'b0;
            // A completion on the issue edge refills the hold register, so it wins.
            if (i_complete)
                r_hold_full <= 1'b1;
            else if (w_take)
                r_hold_full <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_complete)
                        r_state <= PEND;
                end
                PEND: begin
                    if (i_encoder_ready) begin
                        r_state <= LOCK;
                        r_lat   <= LAT_LOAD;
                        r_valid <= 1'b1;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                LOCK: begin
                    r_lat <= r_lat - 3'd1;
                    if (r_lat == LAT_LAST)
                        r_state <= (r_hold_full || i_complete) ? PEND : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/aes_plain_block_packer.sv
// Packs 32-bit plaintext words into 128-bit blocks and issues them to the AES encoder.
// Optional zero-padded short final block when AES_PACK_PAD_EN is defined.
module aes_plain_block_packer
    import aes_pkg::*;
#(
    parameter int READY_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic [AES_WORD_W-1:0]  in_word,
    input  logic                   in_word_valid,
    input  logic                   in_word_last,
    output logic                   out_word_ready,
    input  logic                   in_encoder_ready,
    output logic [AES_BLOCK_W-1:0] out_plain_data,
    output logic                   out_plain_data_valid,
    output logic [CNT_W-1:0]       out_block_count,
    output logic                   out_busy
);
    logic [AES_BLOCK_W-1:0] r_fill;
    logic [AES_BLOCK_W-1:0] r_hold;
    logic [AES_BLOCK_W-1:0] r_plain;
    logic [1:0]             r_index;

    logic [AES_BLOCK_W-1:0] w_block;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_complete;
    logic                   w_take;
    logic                   w_hold_full;
    logic                   w_idle;

`ifdef AES_PACK_PAD_EN
    assign w_last = in_word_last;
    // A short last word would overwrite a held block unless it leaves on this edge.
    assign out_word_ready = !in_reset &&
        !(w_hold_full && ((r_index == 2'd3) || (in_word_last && !w_take)));
`else
    logic w_unused_last;
    assign w_unused_last  = in_word_last;
    assign w_last         = 1'b0;
    assign out_word_ready = !in_reset && !(w_hold_full && (r_index == 2'd3));
`endif

    assign w_accept   = in_word_valid && out_word_ready;
    assign w_complete = w_accept && ((r_index == 2'd3) || w_last);

    always_comb begin
        w_block = r_fill;
        case (r_index)
            2'd0:    w_block[127:96] = in_word;
            2'd1:    w_block[95:64]  = in_word;
            2'd2:    w_block[63:32]  = in_word;
            default: w_block[31:0]   = in_word;
        endcase
    end

    // Fill is cleared on completion so unwritten slots of a short block read as zero.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_fill  <= '0;
            r_hold  <= '0;
            r_plain <= '0;
            r_index <= 2'd0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_hold  <= w_block;
                    r_fill  <= '0;
                    r_index <= 2'd0;
                end else begin
                    r_fill  <= w_block;
                    r_index <= r_index + 2'd1;
                end
            end
            if (w_take)
                r_plain <= r_hold;
        end
    end

    aes_pack_issue_fsm #(
        .READY_LAT (READY_LAT),
        .CNT_W     (CNT_W)
    ) u_issue_fsm (
        .i_clk           (in_clk),
        .i_rst           (in_reset),
        .i_complete      (w_complete),
        .i_encoder_ready (in_encoder_ready),
        .o_take          (w_take),
        .o_valid         (out_plain_data_valid),
        .o_hold_full     (w_hold_full),
        .o_idle          (w_idle),
        .o_count         (out_block_count)
    );

    assign out_plain_data = r_plain;
    assign out_busy       = w_hold_full || (r_index != 2'd0) || !w_idle;
endmodule

// File: tb/tb_aes_plain_block_packer.sv
// Directed and scoreboarded bench for aes_plain_block_packer (READY_LAT=1, CNT_W=4).
module tb_aes_plain_block_packer;
    localparam int RL = 1;
    localparam int CW = 4;

    logic          in_clk = 1'b0;
    logic          in_reset = 1'b1;
    logic [31:0]   in_word = '0;
    logic          in_word_valid = 1'b0;
    logic          in_word_last = 1'b0;
    logic          out_word_ready;
    logic          in_encoder_ready = 1'b0;
    logic [127:0]  out_plain_data;
    logic          out_plain_data_valid;
    logic [CW-1:0] out_block_count;
    logic          out_busy;

    int passed = 0;
    int total  = 0;

    int           cyc = 0;
    int           last_pulse = -1000;
    int           min_gap = 1000;
    logic [127:0] pq[$];
    int           pcyc[$];

    aes_plain_block_packer #(.READY_LAT(RL), .CNT_W(CW)) dut (
        .in_clk               (in_clk),
        .in_reset             (in_reset),
        .in_word              (in_word),
        .in_word_valid        (in_word_valid),
        .in_word_last         (in_word_last),
        .out_word_ready       (out_word_ready),
        .in_encoder_ready     (in_encoder_ready),
        .out_plain_data       (out_plain_data),
        .out_plain_data_valid (out_plain_data_valid),
        .out_block_count      (out_block_count),
        .out_busy             (out_busy)
    );

    always #5 in_clk = ~in_clk;

    always begin
        @(posedge in_clk);
        #1;
        cyc++;
        if (out_plain_data_valid) begin
            pq.push_back(out_plain_data);
            pcyc.push_back(cyc);
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge in_clk);
            #2;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        in_word = w; in_word_valid = 1'b1; in_word_last = last;
        while (!out_word_ready && n < 500) begin tick(); n++; end
        if (n >= 500) begin
            total++;
            $display("FAIL send_word: ready never rose for word %h", w);
        end
        tick();
        in_word_valid = 1'b0; in_word_last = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pq.size() < n && k < budget) begin tick(); k++; end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        tick(2);
        total++; if (out_word_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", out_word_ready); else passed++;
        total++; if (out_plain_data !== 128'h0) $display("FAIL rst_data: got %h want 0", out_plain_data); else passed++;
        total++; if (out_plain_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_plain_data_valid); else passed++;
        total++; if (out_block_count !== 4'd0) $display("FAIL rst_count: got %0d want 0", out_block_count); else passed++;
        total++; if (out_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", out_busy); else passed++;
        in_reset = 1'b0;
        tick();
        total++; if (out_word_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", out_word_ready); else passed++;
    endtask

    task automatic test_single_block();
        pq.delete(); pcyc.delete();
        in_encoder_ready = 1'b1;
        send_word(32'h00112233, 1'b0);
        send_word(32'h44556677, 1'b0);
        send_word(32'h8899aabb, 1'b0);
        send_word(32'hccddeeff, 1'b0);
        wait_pulses(1, 20);
        total++; if (pq.size() !== 1) $display("FAIL single_pulses: got %0d want 1", pq.size()); else passed++;
        total++; if (pq[0] !== 128'h00112233445566778899aabbccddeeff) $display("FAIL single_data: got %h want 00112233445566778899aabbccddeeff", pq[0]); else passed++;
        total++; if (out_block_count !== 4'd1) $display("FAIL single_count: got %0d want 1", out_block_count); else passed++;
        tick(3);
        total++; if (out_plain_data !== 128'h00112233445566778899aabbccddeeff) $display("FAIL single_hold: got %h want 00112233445566778899aabbccddeeff", out_plain_data); else passed++;
        total++; if (out_busy !== 1'b0) $display("FAIL single_busy: got %b want 0", out_busy); else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        pq.delete(); pcyc.delete();
        in_encoder_ready = 1'b0;
        send_word(32'ha0a0a0a0, 1'b0);
        send_word(32'ha1a1a1a1, 1'b0);
        send_word(32'ha2a2a2a2, 1'b0);
        send_word(32'ha3a3a3a3, 1'b0);
        send_word(32'hb0b0b0b0, 1'b0);
        send_word(32'hb1b1b1b1, 1'b0);
        send_word(32'hb2b2b2b2, 1'b0);
        in_word = 32'hb3b3b3b3; in_word_valid = 1'b1;
        tick(3);
        total++; if (out_word_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b want 0", out_word_ready); else passed++;
        total++; if (pq.size() !== 0) $display("FAIL bp_no_pulse: got %0d want 0", pq.size()); else passed++;
        total++; if (out_busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", out_busy); else passed++;
        in_encoder_ready = 1'b1;
        n = 0;
        while (!out_word_ready && n < 50) begin tick(); n++; end
        tick();
        in_word_valid = 1'b0;
        wait_pulses(2, 30);
        total++; if (pq.size() !== 2) $display("FAIL bp_pulses: got %0d want 2", pq.size()); else passed++;
        total++; if (pq[0] !== 128'ha0a0a0a0a1a1a1a1a2a2a2a2a3a3a3a3) $display("FAIL bp_first: got %h want a0a0a0a0a1a1a1a1a2a2a2a2a3a3a3a3", pq[0]); else passed++;
        total++; if (pq[1] !== 128'hb0b0b0b0b1b1b1b1b2b2b2b2b3b3b3b3) $display("FAIL bp_second: got %h want b0b0b0b0b1b1b1b1b2b2b2b2b3b3b3b3", pq[1]); else passed++;
        total++; if (pcyc[1] - pcyc[0] !== RL + 1) $display("FAIL bp_spacing: got %0d want %0d", pcyc[1] - pcyc[0], RL + 1); else passed++;
        total++; if (out_block_count !== 4'd3) $display("FAIL bp_count: got %0d want 3", out_block_count); else passed++;
    endtask

    task automatic test_reset_mid();
        pq.delete(); pcyc.delete();
        in_encoder_ready = 1'b0;
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b0);
        send_word(32'h55555555, 1'b0);
        send_word(32'h66666666, 1'b0);
        total++; if (out_busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", out_busy); else passed++;
        in_reset = 1'b1;
        #1;
        total++; if (out_plain_data !== 128'h0) $display("FAIL mid_data: got %h want 0", out_plain_data); else passed++;
        total++; if (out_block_count !== 4'd0) $display("FAIL mid_count: got %0d want 0", out_block_count); else passed++;
        total++; if (out_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", out_busy); else passed++;
        total++; if (out_word_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", out_word_ready); else passed++;
        tick();
        in_reset = 1'b0;
        in_encoder_ready = 1'b1;
        tick(5);
        total++; if (pq.size() !== 0) $display("FAIL mid_no_pulse: got %0d want 0", pq.size()); else passed++;
        send_word(32'hc0c0c0c0, 1'b0);
        send_word(32'hc1c1c1c1, 1'b0);
        send_word(32'hc2c2c2c2, 1'b0);
        send_word(32'hc3c3c3c3, 1'b0);
        wait_pulses(1, 20);
        total++; if (pq[0] !== 128'hc0c0c0c0c1c1c1c1c2c2c2c2c3c3c3c3) $display("FAIL mid_fresh: got %h want c0c0c0c0c1c1c1c1c2c2c2c2c3c3c3c3", pq[0]); else passed++;
        total++; if (out_block_count !== 4'd1) $display("FAIL mid_fresh_count: got %0d want 1", out_block_count); else passed++;
    endtask

    task automatic test_pad();
        pq.delete(); pcyc.delete();
        in_encoder_ready = 1'b1;
        send_word(32'hdeadbeef, 1'b0);
        send_word(32'h01020304, 1'b1);
`ifdef AES_PACK_PAD_EN
        wait_pulses(1, 20);
        total++; if (pq.size() !== 1) $display("FAIL pad_pulses: got %0d want 1", pq.size()); else passed++;
        total++; if (pq[0] !== 128'hdeadbeef010203040000000000000000) $display("FAIL pad_data: got %h want deadbeef010203040000000000000000", pq[0]); else passed++;
        total++; if (out_busy !== 1'b0) $display("FAIL pad_busy: got %b want 0", out_busy); else passed++;
`else
        tick(20);
        total++; if (pq.size() !== 0) $display("FAIL nopad_pulses: got %0d want 0", pq.size()); else passed++;
        total++; if (out_busy !== 1'b1) $display("FAIL nopad_busy: got %b want 1", out_busy); else passed++;
`endif
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        pq.delete(); pcyc.delete();
        in_encoder_ready = 1'b1;
        for (int b = 0; b < 17; b++)
            for (int j = 0; j < 4; j++)
                send_word(32'(b * 4 + j), 1'b0);
        wait_pulses(17, 200);
        total++; if (pq.size() !== 17) $display("FAIL wrap_pulses: got %0d want 17", pq.size()); else passed++;
        total++; if (out_block_count !== 4'd1) $display("FAIL wrap_count: got %0d want 1", out_block_count); else passed++;
        total++; if (pq[16] !== {32'd64, 32'd65, 32'd66, 32'd67}) $display("FAIL wrap_last_data: got %h", pq[16]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        bit           done;
        int           bad;
        int           first_bad;
        pq.delete(); pcyc.delete();
        done = 1'b0;
        fork
            begin
                logic [31:0] w[4];
                for (int b = 0; b < 100; b++) begin
                    for (int j = 0; j < 4; j++) w[j] = $urandom;
                    exp_q.push_back({w[0], w[1], w[2], w[3]});
                    for (int j = 0; j < 4; j++) send_word(w[j], 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    in_encoder_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        in_encoder_ready = 1'b1;
        wait_pulses(100, 2000);
        total++; if (pq.size() !== 100) $display("FAIL b2b_pulses: got %0d want 100", pq.size()); else passed++;
        bad = 0; first_bad = -1;
        for (int i = 0; i < 100 && i < pq.size(); i++)
            if (pq[i] !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        total++; if (bad !== 0) $display("FAIL b2b_scoreboard: %0d blocks differ, first at %0d", bad, first_bad); else passed++;
        total++; if (out_block_count !== 4'd5) $display("FAIL b2b_count: got %0d want 5", out_block_count); else passed++;
        total++; if (min_gap < RL + 1) $display("FAIL pulse_gap: got %0d want >= %0d", min_gap, RL + 1); else passed++;
        tick(4);
        total++; if (out_busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", out_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_reset_mid();
        test_pad();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
